matrix_win3x3_ctrl: RTL and testbench

Sequencer for the two 8-bit prefetch line-buffer FIFOs used by the Gaussian filter. Per pixel it decides when each FIFO is pushed and popped, cascades FIFO0 output into FIFO1, and builds a registered 3x3 pixel window with its valid strobe. It also tracks column and row position, drains stale FIFO contents at frame start, and flags FIFO underflow. It sits between the pixel stream source and the 3x3 Gaussian kernel.

---
 rtl/matrix_pkg.sv | 26 ++
 rtl/matrix_win3x3_shift.sv | 66 ++++++
 rtl/matrix_win3x3_ctrl.sv | 166 ++++++++++++++++
 tb/tb_matrix_win3x3_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and constants for the 3x3 window sequencer
package matrix_pkg;

    localparam int DATA_W_DFLT = 8;
    localparam int CNT_W_DFLT  = 12;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        ROW0,
        ROW1,
        STEADY
    } state_t;

    // Tap slots in win_data, row-major from top-left; bit offset = TAP_xx * DATA_W
    localparam int TAP_11 = 8;
    localparam int TAP_12 = 7;
    localparam int TAP_13 = 6;
    localparam int TAP_21 = 5;
    localparam int TAP_22 = 4;
    localparam int TAP_23 = 3;
    localparam int TAP_31 = 2;
    localparam int TAP_32 = 1;
    localparam int TAP_33 = 0;

endpackage

// File: rtl/matrix_win3x3_shift.sv
// rtl/matrix_win3x3_shift.sv - three 3-deep window rows with optional left-border zeroing
// Optional: MATRIX_BORDER_ZERO_EN zeroes taps left of column 0 as each line starts.
module matrix_win3x3_shift
    import matrix_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic                  col_first,
    input  logic                  col_second,
    input  logic [DATA_W-1:0]     bot_in,
    input  logic [DATA_W-1:0]     mid_in,
    input  logic [DATA_W-1:0]     top_in,
    output logic [9*DATA_W-1:0]   win_data
);

    logic [DATA_W-1:0] top_q [3];
    logic [DATA_W-1:0] mid_q [3];
    logic [DATA_W-1:0] bot_q [3];
    logic              keep0;
    logic              keep1;

`ifdef MATRIX_BORDER_ZERO_EN
    // Older columns belong to the previous line when the new pixel sits at col 0/1
    assign keep0 = ~(col_first | col_second);
    assign keep1 = ~col_first;
`else
    logic unused_cols;
    assign unused_cols = col_first | col_second;
    assign keep0 = 1'b1;
    assign keep1 = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                top_q[i] <= '0;
                mid_q[i] <= '0;
                bot_q[i] <= '0;
            end
        end else if (shift_en) begin
            top_q[0] <= keep0 ? top_q[1] : '0;
            top_q[1] <= keep1 ? top_q[2] : '0;
            top_q[2] <= top_in;
            mid_q[0] <= keep0 ? mid_q[1] : '0;
            mid_q[1] <= keep1 ? mid_q[2] : '0;
            mid_q[2] <= mid_in;
            bot_q[0] <= keep0 ? bot_q[1] : '0;
            bot_q[1] <= keep1 ? bot_q[2] : '0;
            bot_q[2] <= bot_in;
        end
    end

    assign win_data[TAP_11*DATA_W +: DATA_W] = top_q[0];
    assign win_data[TAP_12*DATA_W +: DATA_W] = top_q[1];
    assign win_data[TAP_13*DATA_W +: DATA_W] = top_q[2];
    assign win_data[TAP_21*DATA_W +: DATA_W] = mid_q[0];
    assign win_data[TAP_22*DATA_W +: DATA_W] = mid_q[1];
    assign win_data[TAP_23*DATA_W +: DATA_W] = mid_q[2];
    assign win_data[TAP_31*DATA_W +: DATA_W] = bot_q[0];
    assign win_data[TAP_32*DATA_W +: DATA_W] = bot_q[1];
    assign win_data[TAP_33*DATA_W +: DATA_W] = bot_q[2];

endmodule

// File: rtl/matrix_win3x3_ctrl.sv
// rtl/matrix_win3x3_ctrl.sv - line-buffer FIFO sequencer and 3x3 window builder
// Optional: MATRIX_BORDER_ZERO_EN emits a window for every pixel with out-of-image taps zeroed.
module matrix_win3x3_ctrl
    import matrix_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = DATA_W_DFLT,
    parameter int CNT_W      = CNT_W_DFLT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  pix_vld,
    input  logic [DATA_W-1:0]     pix_data,
    output logic                  pix_rdy,
    output logic                  f0_wr_en,
    output logic [DATA_W-1:0]     f0_wr_data,
    output logic                  f0_rd_en,
    input  logic [DATA_W-1:0]     f0_rd_data,
    input  logic                  f0_rd_vld,
    output logic                  f1_wr_en,
    output logic [DATA_W-1:0]     f1_wr_data,
    output logic                  f1_rd_en,
    input  logic [DATA_W-1:0]     f1_rd_data,
    input  logic                  f1_rd_vld,
    output logic                  win_vld,
    output logic [9*DATA_W-1:0]   win_data,
    output logic [CNT_W-1:0]      win_col,
    output logic [CNT_W-1:0]      win_row,
    output logic                  underflow
);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  col;
    logic [CNT_W-1:0]  row;
    logic              acc;
    logic              col_last;
    logic              row_last;
    logic              uf_hit;
    logic              win_hit;
    logic [DATA_W-1:0] mid_in;
    logic [DATA_W-1:0] top_in;

    // A frame_start beat never carries a pixel, even mid-frame
    assign pix_rdy  = ((state == ROW0) || (state == ROW1) || (state == STEADY)) && !frame_start;
    assign acc      = pix_vld && pix_rdy;
    assign col_last = (col == CNT_W'(IMG_WIDTH - 1));
    assign row_last = (row == CNT_W'(IMG_HEIGHT - 1));

    assign f0_wr_data = pix_data;
    assign f1_wr_data = f0_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        f0_wr_en  = 1'b0;
        f0_rd_en  = 1'b0;
        f1_wr_en  = 1'b0;
        f1_rd_en  = 1'b0;
        uf_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) state_nxt = DRAIN;
            end
            DRAIN: begin
                f0_rd_en = f0_rd_vld;
                f1_rd_en = f1_rd_vld;
                if (!f0_rd_vld && !f1_rd_vld) state_nxt = ROW0;
            end
            ROW0: begin
                if (acc) begin
                    f0_wr_en = 1'b1;
                    if (col_last) state_nxt = ROW1;
                end
            end
            ROW1: begin
                if (acc) begin
                    f0_wr_en = 1'b1;
                    f0_rd_en = 1'b1;
                    f1_wr_en = 1'b1;
                    uf_hit   = !f0_rd_vld;
                    if (col_last) state_nxt = STEADY;
                end
            end
            STEADY: begin
                if (acc) begin
                    f0_wr_en = 1'b1;
                    f0_rd_en = 1'b1;
                    f1_wr_en = 1'b1;
                    f1_rd_en = 1'b1;
                    uf_hit   = !f0_rd_vld || !f1_rd_vld;
                    if (col_last && row_last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (frame_start) state_nxt = DRAIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (frame_start) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (col_last) begin
                col <= '0;
                row <= (state == STEADY && row_last) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Lines not yet buffered, and missing heads, enter the window as zero
    assign mid_in = ((state == ROW1 || state == STEADY) && f0_rd_vld) ? f0_rd_data : '0;
    assign top_in = ((state == STEADY) && f1_rd_vld) ? f1_rd_data : '0;

`ifdef MATRIX_BORDER_ZERO_EN
    assign win_hit = acc;
`else
    assign win_hit = acc && (row >= CNT_W'(2)) && (col >= CNT_W'(2));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_vld   <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
            underflow <= 1'b0;
        end else begin
            win_vld   <= win_hit;
            underflow <= underflow || uf_hit;
            if (acc) begin
                win_col <= col;
                win_row <= row;
            end
        end
    end

    matrix_win3x3_shift #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (acc),
        .col_first  (col == '0),
        .col_second (col == CNT_W'(1)),
        .bot_in     (pix_data),
        .mid_in     (mid_in),
        .top_in     (top_in),
        .win_data   (win_data)
    );

endmodule

// File: tb/tb_matrix_win3x3_ctrl.sv
// tb/tb_matrix_win3x3_ctrl.sv - directed self-checking bench for matrix_win3x3_ctrl on a 4x4 frame
module tb_matrix_win3x3_ctrl;

    localparam int W = 4;
    localparam int H = 4;
`ifdef MATRIX_BORDER_ZERO_EN
    localparam int          NWIN      = 16;
    localparam logic [71:0] FIRST_EXP = 72'h0;
`else
    localparam int          NWIN      = 4;
    localparam logic [71:0] FIRST_EXP = 72'h00_01_02_10_11_12_20_21_22;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        pix_vld = 1'b0;
    logic [7:0]  pix_data = 8'h0;
    logic        pix_rdy;
    logic        f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en;
    logic [7:0]  f0_wr_data, f1_wr_data, f0_rd_data, f1_rd_data;
    logic        f0_rd_vld, f1_rd_vld;
    logic        win_vld;
    logic [71:0] win_data;
    logic [11:0] win_col, win_row;
    logic        underflow;

    int checks = 0;
    int failures = 0;

    matrix_win3x3_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DATA_W    (8),
        .CNT_W     (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .pix_vld    (pix_vld),
        .pix_data   (pix_data),
        .pix_rdy    (pix_rdy),
        .f0_wr_en   (f0_wr_en),
        .f0_wr_data (f0_wr_data),
        .f0_rd_en   (f0_rd_en),
        .f0_rd_data (f0_rd_data),
        .f0_rd_vld  (f0_rd_vld),
        .f1_wr_en   (f1_wr_en),
        .f1_wr_data (f1_wr_data),
        .f1_rd_en   (f1_rd_en),
        .f1_rd_data (f1_rd_data),
        .f1_rd_vld  (f1_rd_vld),
        .win_vld    (win_vld),
        .win_data   (win_data),
        .win_col    (win_col),
        .win_row    (win_row),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    // Prefetch FIFO models; a pop only happens when the DUT sees a valid head
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       v0_r = 1'b0, v1_r = 1'b0;
    logic [7:0] h0_r = 8'h0, h1_r = 8'h0;
    logic       kill0 = 1'b0;
    logic       pre0 = 1'b0, pre1 = 1'b0;
    int         p0cnt = 0, p1cnt = 0;

    assign f0_rd_vld  = v0_r && !kill0;
    assign f0_rd_data = h0_r;
    assign f1_rd_vld  = v1_r;
    assign f1_rd_data = h1_r;

    always @(posedge clk) begin
        if (f0_rd_en && f0_rd_vld && q0.size() != 0) begin
            void'(q0.pop_front());
            p0cnt++;
        end
        if (f1_rd_en && f1_rd_vld && q1.size() != 0) begin
            void'(q1.pop_front());
            p1cnt++;
        end
        if (f0_wr_en) q0.push_back(f0_wr_data);
        if (f1_wr_en) q1.push_back(f1_wr_data);
        if (pre0) q0.push_back(8'hA5);
        if (pre1) q1.push_back(8'h5A);
        v0_r <= (q0.size() != 0);
        h0_r <= (q0.size() != 0) ? q0[0] : 8'h0;
        v1_r <= (q1.size() != 0);
        h1_r <= (q1.size() != 0) ? q1[0] : 8'h0;
    end

    // Window capture
    logic        acc_d = 1'b0;
    int          nwin = 0;
    int          orphan = 0;
    logic [71:0] wdat [256];
    logic [11:0] wcol [256];
    logic [11:0] wrow [256];

    always @(posedge clk) acc_d <= pix_vld && pix_rdy;

    always @(negedge clk) begin
        if (win_vld) begin
            if (!acc_d) orphan++;
            if (nwin < 256) begin
                wdat[nwin] = win_data;
                wcol[nwin] = win_col;
                wrow[nwin] = win_row;
            end
            nwin++;
        end
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] win_exp(input int r, input int c);
        logic [71:0] res;
        res = '0;
        for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
                int pr, pc;
                pr = r - 2 + rr;
                pc = c - 2 + cc;
                if (pr >= 0 && pc >= 0)
                    res[(8 - (rr * 3 + cc)) * 8 +: 8] = 8'(16 * pr + pc);
            end
        end
        return res;
    endfunction

    int dp0, dp1, wait_cyc;

    task automatic start_frame();
        int s0, s1;
        s0 = p0cnt;
        s1 = p1cnt;
        frame_start = 1'b1;
        pix_vld     = 1'b1;
        pix_data    = 8'hEE;
        @(negedge clk);
        frame_start = 1'b0;
        pix_vld     = 1'b0;
        wait_cyc    = 0;
        while (!pix_rdy && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        dp0 = p0cnt - s0;
        dp1 = p1cnt - s1;
        chk("drain_done", pix_rdy, 1'b1);
    endtask

    task automatic send_beats(input int start, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int idx, t;
            idx      = start + i;
            pix_vld  = 1'b1;
            pix_data = 8'(16 * (idx / W) + (idx % W));
            t = 0;
            while (!pix_rdy && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) chk("beat_timeout", 1'b0, 1'b1);
            @(negedge clk);
            pix_vld = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic check_windows(input int base, input int obase);
        int n;
        n = nwin - base;
        chk("win_count", 72'(n), 72'(NWIN));
        chk("win_orphan", 72'(orphan - obase), 72'd0);
        chk("win_first", wdat[base], FIRST_EXP);
        for (int k = 0; k < n && k < NWIN; k++) begin
            int er, ec;
`ifdef MATRIX_BORDER_ZERO_EN
            er = k / W;
            ec = k % W;
`else
            er = 2 + k / 2;
            ec = 2 + k % 2;
`endif
            chk("win_row", 72'(wrow[base + k]), 72'(er));
            chk("win_col", 72'(wcol[base + k]), 72'(ec));
            chk("win_data", wdat[base + k], win_exp(er, ec));
        end
    endtask

    int base, obase;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pix_rdy", pix_rdy, 1'b0);
        chk("rst_win_vld", win_vld, 1'b0);
        chk("rst_win_data", win_data, 72'h0);
        chk("rst_win_col", win_col, 12'h0);
        chk("rst_win_row", win_row, 12'h0);
        chk("rst_underflow", underflow, 1'b0);
        chk("rst_enables", {f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en}, 4'b0);

        // Preload 3/2 stale entries, then a continuous frame
        pre0 = 1'b1;
        pre1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pre1 = 1'b0;
        @(negedge clk);
        pre0 = 1'b0;
        @(negedge clk);
        chk("idle_no_pop", {f0_rd_en, f1_rd_en}, 2'b0);
        base  = nwin;
        obase = orphan;
        start_frame();
        chk("pre_drain_f0", 72'(dp0), 72'd3);
        chk("pre_drain_f1", 72'(dp1), 72'd2);
        chk("pre_drain_cycles", (wait_cyc >= 3 && wait_cyc <= 5), 1'b1);
        send_beats(0, W * H, 0);
        repeat (3) @(negedge clk);
        check_windows(base, obase);
        chk("cont_underflow", underflow, 1'b0);
        chk("end_idle_rdy", pix_rdy, 1'b0);

        // Same frame with a gap after each beat
        base  = nwin;
        obase = orphan;
        start_frame();
        chk("gap_drain_f0", 72'(dp0), 72'd4);
        chk("gap_drain_f1", 72'(dp1), 72'd4);
        send_beats(0, W * H, 1);
        repeat (3) @(negedge clk);
        check_windows(base, obase);

        // Abort at row 2 col 1 with a same-cycle pixel that must be ignored
        base = nwin;
        start_frame();
        send_beats(0, 2 * W + 1, 0);
        repeat (2) @(negedge clk);
        chk("abort_no_win", 72'(nwin - base), 72'(`ifdef MATRIX_BORDER_ZERO_EN 2 * W + 1 `else 0 `endif));
        base  = nwin;
        obase = orphan;
        start_frame();
        chk("abort_drain_f0", 72'(dp0), 72'd4);
        chk("abort_drain_f1", 72'(dp1), 72'd4);
        chk("abort_fifo_empty", 72'(q0.size() + q1.size()), 72'd0);
        send_beats(0, W * H, 0);
        repeat (3) @(negedge clk);
        check_windows(base, obase);

        // Missing FIFO0 head on a ROW1 beat
        start_frame();
        send_beats(0, W, 0);
        chk("pre_uf_clear", underflow, 1'b0);
        kill0 = 1'b1;
        send_beats(W, 1, 0);
        kill0 = 1'b0;
        chk("uf_set", underflow, 1'b1);
        send_beats(W + 1, W * H - W - 1, 0);
        repeat (3) @(negedge clk);
        chk("uf_sticky_frame", underflow, 1'b1);
        base  = nwin;
        obase = orphan;
        start_frame();
        send_beats(0, W * H, 0);
        repeat (3) @(negedge clk);
        check_windows(base, obase);
        chk("uf_sticky_next", underflow, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("uf_rst", underflow, 1'b0);
        chk("uf_rst_rdy", pix_rdy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
